abc_logic: RTL and testbench
============================

Name: abc_logic

Overview:
- Evaluates the three-input Boolean function y = (a AND b) OR (NOT b AND c), the canonical "AB + B'C" selector: b chooses between a and c.
- y is purely combinational, so it is valid within the same simulation time step as its inputs, with no clock edge needed.
- Also provides a clocked observation path: a registered copy of y, a y rising-edge strobe, the registered input minterm index, and a saturating count of cycles where y was high.
- Sits as a small glue/select cell; the registered outputs feed status logic.

Parameters:
- CNT_W, 8, width of the y-high cycle counter (legal range 1..32).

Ports:
- clk        input   1      rising-edge clock for all registered outputs
- rst_n      input   1      asynchronous active-low reset
- a          input   1      function input A (selected when b=1)
- b          input   1      select input B
- c          input   1      function input C (selected when b=0)
- y          output  1      combinational result: a&b | ~b&c
- y_q        output  1      y registered on clk
- y_rise     output  1      one-cycle pulse when y goes from 0 to 1, registered
- minterm_q  output  3      registered {a,b,c}, with a as MSB
- hi_count   output  CNT_W  saturating count of clock edges that sampled y=1

Behaviour:
- Truth table for y, listed as abc -> y: 000->0, 001->1, 010->0, 011->0, 100->0, 101->1, 110->1, 111->1.
- y depends only on a, b and c. It is independent of clk and rst_n, including while reset is asserted.
- When b=1, y=a. When b=0, y=c.
- If any input is X or Z, y is X. No X-masking is performed.
- Reset: rst_n=0 immediately forces the registered outputs, with no clock needed:
  - y_q=0
  - y_rise=0
  - minterm_q=3'b000
  - hi_count=0
  - an internal y_prev register is also cleared to 0.
- Reset release is seen on the first rising clk edge at which rst_n is sampled as 1.
- On each rising clk edge while rst_n=1:
  - y_q <= y
  - minterm_q <= {a,b,c}
  - y_rise <= y & ~y_prev, then y_prev <= y
  - if y=1 and hi_count < 2^CNT_W-1, hi_count increments by 1; otherwise it holds.
- Latency: y has 0 cycles of latency. y_q, minterm_q and y_rise have 1 cycle of latency. hi_count reflects the new value 1 cycle after the sample.
- y_rise after reset: y_prev resets to 0, so if y=1 on the first post-reset edge, y_rise pulses.
- y_rise while y stays high: y_rise is asserted for exactly one cycle per 0->1 transition of the sampled y.
- Counter saturation: at all-ones, hi_count holds. It never wraps.
- Reset mid-operation: all registered outputs clear asynchronously. The count restarts from 0.
- Single clock domain. No handshake. Inputs are sampled as-is; any synchronisation is the caller's responsibility.

Test Plan:
- Combinational sweep, with clk idle and rst_n in any state: drive abc through 000..111 in order, 10 time units each, and check y at each step. Required y: 0,1,0,0,0,1,1,1.
- Reset:
  - With rst_n=0, apply abc=110.
  - Required: y=1 immediately, while y_q=0, y_rise=0, minterm_q=000 and hi_count=0, held until the first edge after release.
- Register latency:
  - After reset, apply abc=101 and clock once.
  - Required: y_q=1, minterm_q=101, y_rise=1.
  - Hold the inputs and clock again. Required: y_rise=0, hi_count=2.
- Edge detect:
  - Over consecutive cycles apply abc = 001, 001, 011, 001.
  - Required y_rise sequence: 1, 0, 0, 1.
- Saturation:
  - With CNT_W=3, hold abc=111 for 10 cycles.
  - Required: hi_count climbs to 7 and stays at 7.
  - Asserting rst_n=0 mid-run immediately returns hi_count to 0.

Source files
------------

// File: rtl/abc_logic.sv
// rtl/abc_logic.sv - AB + B'C select cell with registered observation path
// b selects a (b=1) or c (b=0); the registered outputs feed status logic.
module abc_logic #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic [2:0]       minterm_q,
  output logic [CNT_W-1:0] hi_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_y_core;
  logic             w_x_taint;
  logic             r_y_q;
  logic             r_y_prev;
  logic             r_y_rise;
  logic [2:0]       r_minterm;
  logic [CNT_W-1:0] r_hi_count;

  assign w_y_core = (a & b) | (~b & c);
  // Folds to 0 for known inputs but carries an X on any input through to y,
  // so an undriven input is never hidden by the AND/OR masking.
  assign w_x_taint = (^{a, b, c}) ^ (^{a, b, c});
  assign y = w_y_core ^ w_x_taint;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q      <= 1'b0;
      r_y_prev   <= 1'b0;
      r_y_rise   <= 1'b0;
      r_minterm  <= 3'b000;
      r_hi_count <= '0;
    end else begin
      r_y_q     <= y;
      r_y_prev  <= y;
      r_y_rise  <= y & ~r_y_prev;
      r_minterm <= {a, b, c};
      if (y && (r_hi_count != CNT_MAX)) begin
        r_hi_count <= r_hi_count + 1'b1;
      end
    end
  end

  assign y_q       = r_y_q;
  assign y_rise    = r_y_rise;
  assign minterm_q = r_minterm;
  assign hi_count  = r_hi_count;

endmodule

// File: tb/tb_abc_logic.sv
// tb/tb_abc_logic.sv - directed and randomized checks for abc_logic
// Two instances share inputs: default 8-bit counter and a 3-bit one for saturation.
module tb_abc_logic;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n, a, b, c;

  logic       y8, yq8, yr8;
  logic [2:0] mq8;
  logic [7:0] hi8;
  logic       y3, yq3, yr3;
  logic [2:0] mq3;
  logic [2:0] hi3;

  int total = 0;
  int bad = 0;

  int m_yq, m_rise, m_prev, m_min, m_c8, m_c3;

  abc_logic u8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .y(y8), .y_q(yq8), .y_rise(yr8), .minterm_q(mq8), .hi_count(hi8)
  );

  abc_logic #(.CNT_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .y(y3), .y_q(yq3), .y_rise(yr3), .minterm_q(mq3), .hi_count(hi3)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_y();
    return (b == 1'b1) ? int'(a) : int'(c);
  endfunction

  task automatic model_reset();
    m_yq = 0; m_rise = 0; m_prev = 0; m_min = 0; m_c8 = 0; m_c3 = 0;
  endtask

  task automatic model_clk();
    int ys;
    ys = ref_y();
    m_rise = (ys == 1 && m_prev == 0) ? 1 : 0;
    m_prev = ys;
    m_yq = ys;
    m_min = 4 * int'(a) + 2 * int'(b) + int'(c);
    if (ys == 1) begin
      m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
      m_c3 = (m_c3 + 1 > 7) ? 7 : m_c3 + 1;
    end
  endtask

  task automatic chk_all(input string ph);
    chk({ph, ".y8"}, 32'(y8), 32'(ref_y()));
    chk({ph, ".y3"}, 32'(y3), 32'(ref_y()));
    chk({ph, ".y_q8"}, 32'(yq8), 32'(m_yq));
    chk({ph, ".y_q3"}, 32'(yq3), 32'(m_yq));
    chk({ph, ".y_rise8"}, 32'(yr8), 32'(m_rise));
    chk({ph, ".y_rise3"}, 32'(yr3), 32'(m_rise));
    chk({ph, ".minterm8"}, 32'(mq8), 32'(m_min));
    chk({ph, ".minterm3"}, 32'(mq3), 32'(m_min));
    chk({ph, ".hi8"}, 32'(hi8), 32'(m_c8));
    chk({ph, ".hi3"}, 32'(hi3), 32'(m_c3));
  endtask

  task automatic step(input logic [2:0] abc, input logic rn);
    @(negedge clk);
    {a, b, c} = abc;
    rst_n = rn;
    if (!rn) model_reset();
    #1;
    chk_all("pre");
    @(posedge clk);
    if (rst_n) model_clk();
    #1;
    chk_all("post");
  endtask

  initial begin
    logic [7:0] tt;
    logic [3:0] rise_exp;
    logic [2:0] edge_seq [4];
    tt = 8'hE2;
    rise_exp = 4'b1001;
    edge_seq[0] = 3'b001; edge_seq[1] = 3'b001;
    edge_seq[2] = 3'b011; edge_seq[3] = 3'b001;

    rst_n = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    model_reset();

    // combinational sweep, clock idle
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #10;
      chk($sformatf("sweep_abc%0d", i), 32'(y8), 32'(tt[i]));
    end

    // reset holds registers while y stays live
    {a, b, c} = 3'b110;
    #1;
    chk("rst_y", 32'(y8), 32'd1);
    chk("rst_y_q", 32'(yq8), 32'd0);
    chk("rst_y_rise", 32'(yr8), 32'd0);
    chk("rst_minterm", 32'(mq8), 32'd0);
    chk("rst_hi", 32'(hi8), 32'd0);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_clocked");

    // register latency
    step(3'b101, 1'b1);
    chk("lat_y_q", 32'(yq8), 32'd1);
    chk("lat_minterm", 32'(mq8), 32'd5);
    chk("lat_rise", 32'(yr8), 32'd1);
    chk("lat_hi1", 32'(hi8), 32'd1);
    step(3'b101, 1'b1);
    chk("lat_rise2", 32'(yr8), 32'd0);
    chk("lat_hi2", 32'(hi8), 32'd2);

    // asynchronous reset mid-operation
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_hi", 32'(hi8), 32'd0);
    chk("midrst_y_q", 32'(yq8), 32'd0);

    // edge detect after reset
    for (int i = 0; i < 4; i++) begin
      step(edge_seq[i], 1'b1);
      chk($sformatf("edge_rise%0d", i), 32'(yr8), 32'(rise_exp[3-i]));
    end

    // saturation on the 3-bit counter
    step(3'b111, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(3'b111, 1'b1);
      chk($sformatf("sat_hi3_%0d", k), 32'(hi3), 32'((k > 7) ? 7 : k));
    end
    chk("sat_hi8", 32'(hi8), 32'd10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("sat_rst_hi3", 32'(hi3), 32'd0);
    chk("sat_rst_hi8", 32'(hi8), 32'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 24) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
